des_round_ctrl: RTL and testbench

DES_ROUND_CTRL -- requirements
Module: des_round_ctrl

---
 rtl/des_round_ctrl.sv | 94 +++++++++
 tb/tb_des_round_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_round_ctrl.sv
// DES Feistel round sequencer: walks 16 rounds against an external f-function,
// then holds the pre-FP result until the consumer takes it.
module des_round_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_valid,
   output logic        start_ready,
   input  logic [63:0] block_in,
   input  logic        decrypt,
   output logic        f_req,
   output logic [31:0] f_r,
   output logic [3:0]  key_idx,
   input  logic        f_valid,
   input  logic [31:0] f_in,
   output logic        done_valid,
   input  logic        done_ready,
   output logic [63:0] block_out
);

   typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

   state_t      state, state_nxt;
   logic [31:0] l_q, l_nxt;
   logic [31:0] r_q, r_nxt;
   logic [3:0]  rnd, rnd_nxt;
   logic        dec_q, dec_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         l_q   <= '0;
         r_q   <= '0;
         rnd   <= '0;
         dec_q <= 1'b0;
      end else begin
         state <= state_nxt;
         l_q   <= l_nxt;
         r_q   <= r_nxt;
         rnd   <= rnd_nxt;
         dec_q <= dec_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      l_nxt       = l_q;
      r_nxt       = r_q;
      rnd_nxt     = rnd;
      dec_nxt     = dec_q;
      start_ready = 1'b0;
      f_req       = 1'b0;
      done_valid  = 1'b0;
      key_idx     = 4'd0;
      f_r         = r_q;
      block_out   = {l_q, r_q};

      case (state)
         IDLE: begin
            start_ready = 1'b1;
            if (start_valid) begin
               l_nxt     = block_in[31:0];
               r_nxt     = block_in[63:32];
               rnd_nxt   = 4'd0;
               dec_nxt   = decrypt;
               state_nxt = ROUND;
            end
         end
         ROUND: begin
            f_req   = 1'b1;
            // ~rnd is 15-rnd for a 4-bit counter, so decrypt order needs no subtractor
            key_idx = dec_q ? ~rnd : rnd;
            if (f_valid) begin
               l_nxt = r_q;
               r_nxt = l_q ^ f_in;
               if (rnd == 4'd15) begin
                  state_nxt = DONE;
               end else begin
                  rnd_nxt = rnd + 4'd1;
               end
            end
         end
         DONE: begin
            done_valid = 1'b1;
            if (done_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_des_round_ctrl.sv
// Scoreboarded bench for des_round_ctrl: stimulus pushes expected results,
// a negedge monitor checks block_out, subkey order and done latency.
module tb_des_round_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_valid;
   logic        start_ready;
   logic [63:0] block_in;
   logic        decrypt;
   logic        f_req;
   logic [31:0] f_r;
   logic [3:0]  key_idx;
   logic        f_valid;
   logic [31:0] f_in;
   logic        done_valid;
   logic        done_ready;
   logic [63:0] block_out;
   logic        fmode;

   des_round_ctrl dut (
      .clk(clk), .rst(rst),
      .start_valid(start_valid), .start_ready(start_ready),
      .block_in(block_in), .decrypt(decrypt),
      .f_req(f_req), .f_r(f_r), .key_idx(key_idx),
      .f_valid(f_valid), .f_in(f_in),
      .done_valid(done_valid), .done_ready(done_ready),
      .block_out(block_out)
   );

   always #5 clk = ~clk;

   // fmode=0: zero f-function; fmode=1: f = R ^ key_idx
   assign f_in = fmode ? (f_r ^ {28'h0, key_idx}) : 32'h0;

   typedef struct {
      logic [63:0] blk;
      logic        dec;
      int          lat;
   } exp_t;

   exp_t       exp_q[$];
   logic [3:0] keys[$];
   int         tests = 0;
   int         fails = 0;
   int         cyc = 0;
   int         acc_edge = 0;
   bit         seen = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [63:0] blk, input logic dec);
      logic [31:0] l, r, t;
      logic [3:0]  k;
      l = blk[31:0];
      r = blk[63:32];
      for (int i = 0; i < 16; i++) begin
         k = dec ? 4'(15 - i) : 4'(i);
         t = l ^ (r ^ {28'h0, k});
         l = r;
         r = t;
      end
      return {l, r};
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: edge index of an event seen at this negedge is cyc+1
   always @(negedge clk) begin
      if (rst) begin
         keys.delete();
         seen = 0;
      end else begin
         if (start_valid && start_ready) begin
            acc_edge = cyc + 1;
            keys.delete();
            seen = 0;
         end
         if (f_req && f_valid) keys.push_back(key_idx);
         if (done_valid && !seen) begin
            seen = 1;
            if (exp_q.size() > 0)
               chk("done_latency", 64'(cyc + 1 - acc_edge), 64'(exp_q[0].lat));
         end
         if (done_valid && done_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_output", 64'(1), 64'(0));
            end else begin
               exp_t e;
               int   bad;
               logic [3:0] want;
               e = exp_q.pop_front();
               chk("block_out", block_out, e.blk);
               bad = (keys.size() != 16) ? 1 : 0;
               for (int i = 0; i < keys.size() && i < 16; i++) begin
                  want = e.dec ? 4'(15 - i) : 4'(i);
                  if (keys[i] !== want) bad = 1;
               end
               tests++;
               if (bad != 0) begin
                  fails++;
                  $display("FAIL key_seq: got %0d keys, first %0d, dec %0d", keys.size(),
                           (keys.size() > 0) ? keys[0] : 4'd0, e.dec);
               end
            end
            seen = 0;
         end
      end
   end

   task automatic send(input logic [63:0] blk, input logic dec, input logic [63:0] exp, input int lat);
      bit ok;
      exp_q.push_back('{exp, dec, lat});
      start_valid = 1'b1;
      block_in    = blk;
      decrypt     = dec;
      ok = 0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (start_ready) ok = 1;
      end
      @(posedge clk);
      #1;
      start_valid = 1'b0;
      if (!ok) chk("accept_timeout", 64'(0), 64'(1));
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'(0));
      @(posedge clk);
      #1;
   endtask

   task automatic wait_key(input logic [3:0] k);
      int n;
      n = 0;
      while (!(f_req && key_idx == k) && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 100) chk("wait_key_timeout", 64'(key_idx), 64'(k));
   endtask

   localparam logic [63:0] ZBLK = 64'h89ABCDEF_01234567;
   localparam logic [63:0] ZEXP = 64'h01234567_89ABCDEF;
   localparam logic [63:0] BLK_A = 64'h0F1E2D3C_4B5A6978;
   localparam logic [63:0] BLK_B = 64'hDEADBEEF_CAFEF00D;

   initial begin
      logic [31:0] snap_r;
      logic [63:0] snap_b;
      int n;
      rst = 1'b1;
      start_valid = 1'b0;
      block_in = '0;
      decrypt = 1'b0;
      f_valid = 1'b1;
      done_ready = 1'b1;
      fmode = 1'b0;
      #2;
      chk("rst_start_ready", 64'(start_ready), 64'(1));
      chk("rst_f_req", 64'(f_req), 64'(0));
      chk("rst_done_valid", 64'(done_valid), 64'(0));
      chk("rst_block_out", block_out, 64'h0);
      chk("rst_f_r", 64'(f_r), 64'h0);
      chk("rst_key_idx", 64'(key_idx), 64'h0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // zero-f encrypt and decrypt
      send(ZBLK, 1'b0, ZEXP, 17);
      drain();
      send(ZBLK, 1'b1, ZEXP, 17);
      drain();

      // reference f, both directions
      fmode = 1'b1;
      send(BLK_A, 1'b0, model(BLK_A, 1'b0), 17);
      drain();
      send(BLK_B, 1'b1, model(BLK_B, 1'b1), 17);
      drain();

      // stall three cycles at round 7
      send(BLK_A, 1'b0, model(BLK_A, 1'b0), 20);
      wait_key(4'd7);
      f_valid = 1'b0;
      snap_r = f_r;
      snap_b = block_out;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("stall_key_idx", 64'(key_idx), 64'(7));
         chk("stall_f_r", 64'(f_r), 64'(snap_r));
         chk("stall_block_out", block_out, snap_b);
      end
      f_valid = 1'b1;
      drain();

      // backpressure with a competing start held high
      done_ready = 1'b0;
      send(BLK_B, 1'b0, model(BLK_B, 1'b0), 17);
      start_valid = 1'b1;
      block_in = BLK_A;
      decrypt = 1'b1;
      n = 0;
      while (!done_valid && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      for (int i = 0; i < 5; i++) begin
         chk("bp_done_valid", 64'(done_valid), 64'(1));
         chk("bp_start_ready", 64'(start_ready), 64'(0));
         chk("bp_block_out", block_out, model(BLK_B, 1'b0));
         if (i < 4) begin
            @(posedge clk);
            #1;
         end
      end
      exp_q.push_back('{model(BLK_A, 1'b1), 1'b1, 17});
      done_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_no_early_accept", 64'(f_req), 64'(0));
      chk("bp_ready_after_hs", 64'(start_ready), 64'(1));
      @(posedge clk);
      #1;
      start_valid = 1'b0;
      chk("bp_accept_next", 64'(f_req), 64'(1));
      drain();

      // reset at round 9 aborts the block
      send(BLK_A, 1'b0, model(BLK_A, 1'b0), 17);
      wait_key(4'd9);
      rst = 1'b1;
      #1;
      void'(exp_q.pop_back());
      chk("mid_rst_start_ready", 64'(start_ready), 64'(1));
      chk("mid_rst_f_req", 64'(f_req), 64'(0));
      chk("mid_rst_done_valid", 64'(done_valid), 64'(0));
      chk("mid_rst_block_out", block_out, 64'h0);
      chk("mid_rst_f_r", 64'(f_r), 64'h0);
      chk("mid_rst_key_idx", 64'(key_idx), 64'h0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      send(BLK_B, 1'b0, model(BLK_B, 1'b0), 17);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
